// File: rtl/sprite_store_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : sprite_store_arbiter_if
// Purpose  : Bundles the two write-requester handshakes, the data-memory
//            write port, the position registers and the error pulse shared
//            between the sprite store arbiter and its surroundings.
// Modports : slave  - the arbiter (takes requests, drives acks/outputs)
//            master - the requesters / memory side
// Revision : 1.0 - initial release
// ============================================================================
interface sprite_store_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic [31:0]       cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic              eng_req;
  logic [31:0]       eng_addr;
  logic [DATA_W-1:0] eng_wdata;
  logic              eng_ack;
  logic              mem_we;
  logic [31:0]       mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] player_pos;
  logic [DATA_W-1:0] enemy1_pos;
  logic [DATA_W-1:0] enemy2_pos;
  logic              wr_err;

  modport slave (
    input  cpu_req, cpu_addr, cpu_wdata, eng_req, eng_addr, eng_wdata,
    output cpu_ack, eng_ack, mem_we, mem_addr, mem_wdata,
           player_pos, enemy1_pos, enemy2_pos, wr_err
  );

  modport master (
    output cpu_req, cpu_addr, cpu_wdata, eng_req, eng_addr, eng_wdata,
    input  cpu_ack, eng_ack, mem_we, mem_addr, mem_wdata,
           player_pos, enemy1_pos, enemy2_pos, wr_err
  );
endinterface
`default_nettype wire

// File: rtl/sprite_store_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sprite_store_arbiter
// Purpose  : Round-robin arbiter between the CPU store port and the enemy
//            movement engine. Each granted write takes two cycles (IDLE grant,
//            WRITE commit) and is decoded into data memory, the player
//            position or one of two enemy position registers.
// Ports    : clk    - system clock, rising edge
//            rst_n  - asynchronous active-low reset
//            bus_io - slave side of sprite_store_arbiter_if (requests, acks,
//                     memory write port, position registers, wr_err)
// Revision : 1.0 - initial release
// ============================================================================
module sprite_store_arbiter #(
  parameter int MEM_LIMIT = 1024,
  parameter int DATA_W    = 32
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  sprite_store_arbiter_if.slave   bus_io
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_WRITE = 1'b1} state_e;
  typedef enum logic [0:0] {SRC_CPU = 1'b0, SRC_ENG = 1'b1} src_e;
  // Register target latched at grant time; protection is already folded in.
  typedef enum logic [1:0] {T_NONE = 2'd0, T_PL = 2'd1, T_E1 = 2'd2, T_E2 = 2'd3} tgt_e;

  localparam logic [31:0] C_PL_LO = 32'(MEM_LIMIT);
  localparam logic [31:0] C_E1_LO = C_PL_LO + 32'd4;
  localparam logic [31:0] C_E2_LO = C_PL_LO + 32'd8;
  localparam logic [31:0] C_END   = C_PL_LO + 32'd12;

  state_e            state_q, state_d;
  src_e              last_src_q, last_src_d;
  tgt_e              tgt_q, tgt_d;
  logic [31:0]       addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              eng_ack_q, eng_ack_d;
  logic              mem_we_q, mem_we_d;
  logic              wr_err_q, wr_err_d;
  logic [DATA_W-1:0] player_q, player_d;
  logic [DATA_W-1:0] enemy1_q, enemy1_d;
  logic [DATA_W-1:0] enemy2_q, enemy2_d;

  logic              w_grant_cpu;
  logic [31:0]       w_sel_addr;
  logic [DATA_W-1:0] w_sel_data;
  logic              w_in_mem, w_in_pl, w_in_e1, w_in_e2;

  // On a tie the requester that did not win last time is granted.
  assign w_grant_cpu = bus_io.cpu_req & (~bus_io.eng_req | (last_src_q == SRC_ENG));
  assign w_sel_addr  = w_grant_cpu ? bus_io.cpu_addr  : bus_io.eng_addr;
  assign w_sel_data  = w_grant_cpu ? bus_io.cpu_wdata : bus_io.eng_wdata;

  // Plain unsigned compares: addresses near 2^32 never wrap into memory.
  assign w_in_mem = (w_sel_addr <  C_PL_LO);
  assign w_in_pl  = (w_sel_addr >= C_PL_LO) && (w_sel_addr < C_E1_LO);
  assign w_in_e1  = (w_sel_addr >= C_E1_LO) && (w_sel_addr < C_E2_LO);
  assign w_in_e2  = (w_sel_addr >= C_E2_LO) && (w_sel_addr < C_END);

  always_comb begin
    state_d    = state_q;
    last_src_d = last_src_q;
    tgt_d      = tgt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cpu_ack_d  = 1'b0;
    eng_ack_d  = 1'b0;
    mem_we_d   = 1'b0;
    wr_err_d   = 1'b0;
    player_d   = player_q;
    enemy1_d   = enemy1_q;
    enemy2_d   = enemy2_q;

    case (state_q)
      S_IDLE: begin
        if (bus_io.cpu_req || bus_io.eng_req) begin
          state_d    = S_WRITE;
          last_src_d = w_grant_cpu ? SRC_CPU : SRC_ENG;
          addr_d     = w_sel_addr;
          wdata_d    = w_sel_data;
          // Ack, write enable and error are registered here so that during
          // WRITE they come straight from flops, not from the req inputs.
          cpu_ack_d  = w_grant_cpu;
          eng_ack_d  = ~w_grant_cpu;
          mem_we_d   = w_in_mem;
          tgt_d      = T_NONE;
          if (w_in_pl && w_grant_cpu) tgt_d = T_PL;
          else if (w_in_e1)           tgt_d = T_E1;
          else if (w_in_e2)           tgt_d = T_E2;
          // Out of range, or engine aiming at the player register.
          wr_err_d   = ~(w_in_mem | w_in_e1 | w_in_e2 | (w_in_pl & w_grant_cpu));
        end
      end
      S_WRITE: begin
        state_d = S_IDLE;
        case (tgt_q)
          T_PL:    player_d = wdata_q;
          T_E1:    enemy1_d = wdata_q;
          T_E2:    enemy2_d = wdata_q;
          default: ;
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      last_src_q <= SRC_ENG;
      tgt_q      <= T_NONE;
      addr_q     <= '0;
      wdata_q    <= '0;
      cpu_ack_q  <= 1'b0;
      eng_ack_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      wr_err_q   <= 1'b0;
      player_q   <= '0;
      enemy1_q   <= '0;
      enemy2_q   <= '0;
    end else begin
      state_q    <= state_d;
      last_src_q <= last_src_d;
      tgt_q      <= tgt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cpu_ack_q  <= cpu_ack_d;
      eng_ack_q  <= eng_ack_d;
      mem_we_q   <= mem_we_d;
      wr_err_q   <= wr_err_d;
      player_q   <= player_d;
      enemy1_q   <= enemy1_d;
      enemy2_q   <= enemy2_d;
    end
  end

  assign bus_io.cpu_ack    = cpu_ack_q;
  assign bus_io.eng_ack    = eng_ack_q;
  assign bus_io.mem_we     = mem_we_q;
  assign bus_io.mem_addr   = addr_q;
  assign bus_io.mem_wdata  = wdata_q;
  assign bus_io.wr_err     = wr_err_q;
  assign bus_io.player_pos = player_q;
  assign bus_io.enemy1_pos = enemy1_q;
  assign bus_io.enemy2_pos = enemy2_q;

endmodule
`default_nettype wire

// File: doc/sprite_store_arbiter.md
# sprite_store_arbiter

Shares the processor's memory-mapped store space between two write requesters: the CPU store port and the enemy-movement engine. It decodes each granted write into data memory (0–1023), player position (1024–1027), enemy 1 position (1028–1031) or enemy 2 position (1032–1035), and owns the three position registers read by the video path. Arbitration is round-robin, with one write committed per two-cycle transaction.

## Interface
- `MEM_LIMIT`, 1024: first address not belonging to data memory.
- `DATA_W`, 32: write data and position register width.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cpu_req`  in  1  CPU write request; held until `cpu_ack`.
- `cpu_addr`  in  32  CPU byte address, unsigned.
- `cpu_wdata`  in  DATA_W  CPU write data.
- `cpu_ack`  out  1  one-cycle pulse: CPU write performed or dropped.
- `eng_req`  in  1  engine write request; held until `eng_ack`.
- `eng_addr`  in  32  engine byte address, unsigned.
- `eng_wdata`  in  DATA_W  engine write data.
- `eng_ack`  out  1  one-cycle pulse: engine write performed or dropped.
- `mem_we`  out  1  data-memory write enable.
- `mem_addr`  out  32  data-memory address (latched address).
- `mem_wdata`  out  DATA_W  data-memory write data.
- `player_pos`  out  DATA_W  player position register.
- `enemy1_pos`  out  DATA_W  enemy 1 position register.
- `enemy2_pos`  out  DATA_W  enemy 2 position register.
- `wr_err`  out  1  one-cycle pulse: the granted write was dropped.

## Operation
- FSM states: IDLE, WRITE.
- IDLE:
  - With no request, stay in IDLE.
  - With any request, pick a winner, latch its address, data and source (`src`), and go to WRITE.
- WRITE: perform the latched write, pulse the winner's ack, then return to IDLE unconditionally. Requests are not sampled in WRITE.
- Arbitration:
  - If only one requester is active, it wins.
  - If both are active, the requester not granted last time wins.
  - `last_src` resets to ENG, so the CPU wins the first tie.
- Decode of the latched address `a`:
  - a < MEM_LIMIT: `mem_we`=1.
  - 1024 ≤ a ≤ 1027: write `player_pos`.
  - 1028 ≤ a ≤ 1031: write `enemy1_pos`.
  - 1032 ≤ a ≤ 1035: write `enemy2_pos`.
  - a ≥ 1036: drop the write and pulse `wr_err`.
- Protection: an engine write to the player range is dropped with `wr_err`. The CPU may write any range.
- Register writes take the full DATA_W word. Low address bits do not select bytes.
- A dropped write is still acked. The requester is never stalled by an error.
- `mem_addr` and `mem_wdata` always show the latched values. They are meaningful only while `mem_we`=1.

## Timing
- Reset values: state IDLE, `cpu_ack`=0, `eng_ack`=0, `mem_we`=0, `wr_err`=0, `mem_addr`=0, `mem_wdata`=0, all position registers 0, `last_src`=ENG.
- The request is sampled at edge E0, when the FSM is in IDLE.
- The WRITE cycle follows E0. During it, `mem_we`, the winner's ack and `wr_err` are driven from registered state, never combinationally from the req inputs.
- The memory samples `mem_we` at edge E1, which ends WRITE. Position registers update at E1 and are visible in the cycle after.
- Ack latency: ack is high exactly one cycle, the cycle after the sampling edge.
- Throughput: at most one write per 2 cycles. With both requesters continuously active, grants alternate CPU, ENG, CPU, …
- Handshake: in the cycle after its ack, a requester either drops req or presents a new request. The arbiter samples it at the next IDLE edge.
- Asserting `rst_n` low mid-WRITE:
  - Outputs clear immediately, without waiting for a clock edge.
  - The latched write is discarded: no memory or register update, no ack.
  - The requester re-issues after reset.
- The address compare is unsigned 32-bit. 0xFFFFFFFC is out of range, with no wrap-around into memory.

## Test plan
- Reset: hold `rst_n`=0 with both reqs high → all outputs 0 and no ack. Release → CPU granted first, `cpu_ack` in the 2nd cycle after release.
- CPU store addr=1020, data=0xDEADBEEF → during WRITE, `mem_we`=1, `mem_addr`=1020, `mem_wdata`=0xDEADBEEF and `cpu_ack`=1, all for one cycle. Position registers unchanged.
- Simultaneous: CPU addr=1024 data=5 and engine addr=1032 data=9, both continuous → CPU acked first, engine acked 2 cycles later. Result: `player_pos`=5, `enemy2_pos`=9, `mem_we` never 1.
- Errors:
  - Engine addr=1026 → `eng_ack`=1 and `wr_err`=1, `player_pos` unchanged.
  - CPU addr=1036 → `cpu_ack`=1 and `wr_err`=1.
  - CPU addr=0xFFFFFFFC → `wr_err`=1 and `mem_we`=0.
- Reset mid-WRITE: CPU addr=1028 data=7, then pulse `rst_n` low during the WRITE cycle → `cpu_ack`, `mem_we` and `wr_err` drop immediately, and `enemy1_pos` stays 0.
